// File: rtl/ctrl_pipe.sv
// Registered RV32I decode/control stage: decodes the ID instruction into a one-entry ID/EX register
// with a valid/ready handshake, load-use bubbles and flush. Define CTRL_RV32M_EN for RV32M decode and the divide hold.
module ctrl_pipe #(
   parameter int ALUOP_W = 5,
   parameter int DIV_LAT = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [31:0]        id_inst,
   output logic               id_ready,
   input  logic               ex_ready,
   output logic               ex_valid,
   output logic               ex_RegWrite,
   output logic               ex_MemWrite,
   output logic               ex_MemRead,
   output logic               ex_ALUSrc,
   output logic               ex_sbtype,
   output logic               ex_jal,
   output logic               ex_jalr,
   output logic [5:0]         ex_EXTOp,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic [2:0]         ex_WDSel,
   output logic [2:0]         ex_DMType,
   output logic [4:0]         ex_rd,
   output logic [4:0]         ex_rs1,
   output logic [4:0]         ex_rs2,
   output logic               ex_illegal,
   output logic               ex_mbusy
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;

   localparam logic [5:0] EXT_SHAMT = 6'b100000;
   localparam logic [5:0] EXT_I     = 6'b010000;
   localparam logic [5:0] EXT_S     = 6'b001000;
   localparam logic [5:0] EXT_B     = 6'b000100;
   localparam logic [5:0] EXT_U     = 6'b000010;
   localparam logic [5:0] EXT_J     = 6'b000001;

   localparam logic [ALUOP_W-1:0] ALU_NOP   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AUIPC = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_BLT   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_BGE   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_BLTU  = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_BGEU  = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(10);
   localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(11);
   localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(12);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(13);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(14);
   localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(15);
   localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(16);
   localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(17);
`ifdef CTRL_RV32M_EN
   localparam logic [ALUOP_W-1:0] ALU_MUL    = ALUOP_W'(18);
   localparam logic [ALUOP_W-1:0] ALU_MULH   = ALUOP_W'(19);
   localparam logic [ALUOP_W-1:0] ALU_MULHSU = ALUOP_W'(20);
   localparam logic [ALUOP_W-1:0] ALU_MULHU  = ALUOP_W'(21);
   localparam logic [ALUOP_W-1:0] ALU_DIV    = ALUOP_W'(22);
   localparam logic [ALUOP_W-1:0] ALU_DIVU   = ALUOP_W'(23);
   localparam logic [ALUOP_W-1:0] ALU_REM    = ALUOP_W'(24);
   localparam logic [ALUOP_W-1:0] ALU_REMU   = ALUOP_W'(25);
   localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
`endif

   localparam logic [2:0] WD_ALU = 3'd0;
   localparam logic [2:0] WD_PC  = 3'd1;
   localparam logic [2:0] WD_W   = 3'd2;
   localparam logic [2:0] WD_H   = 3'd3;
   localparam logic [2:0] WD_B   = 3'd4;
   localparam logic [2:0] WD_HU  = 3'd5;
   localparam logic [2:0] WD_BU  = 3'd6;

   localparam logic [2:0] DM_WORD  = 3'd0;
   localparam logic [2:0] DM_HALF  = 3'd1;
   localparam logic [2:0] DM_HALFU = 3'd2;
   localparam logic [2:0] DM_BYTE  = 3'd3;
   localparam logic [2:0] DM_BYTEU = 3'd4;

   typedef struct packed {
      logic               reg_write;
      logic               mem_write;
      logic               mem_read;
      logic               alu_src;
      logic               sbtype;
      logic               jal;
      logic               jalr;
      logic [5:0]         ext_op;
      logic [ALUOP_W-1:0] alu_op;
      logic [2:0]         wd_sel;
      logic [2:0]         dm_type;
      logic [4:0]         rd;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic               illegal;
   } ctrl_t;

   typedef enum logic {
      RUN = 1'b0
`ifdef CTRL_RV32M_EN
      , MDIV = 1'b1
`endif
   } state_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   ctrl_t      dec;
   logic       dec_legal;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       hazard;
   logic       accept;
`ifdef CTRL_RV32M_EN
   logic       dec_div;
   logic [CNT_W-1:0] cnt_d, cnt_q;
`endif

   state_t state_d, state_q;
   logic   valid_d, valid_q;
   ctrl_t  ctrl_d, ctrl_q;

   assign opcode = id_inst[6:0];
   assign funct3 = id_inst[14:12];
   assign funct7 = id_inst[31:25];

   always_comb begin
      dec       = '0;
      dec.wd_sel = WD_ALU;
      dec.alu_op = ALU_NOP;
      dec_legal = 1'b1;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
`ifdef CTRL_RV32M_EN
      dec_div   = 1'b0;
`endif
      case (opcode)
         OPC_LUI: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_U; dec.alu_op = ALU_LUI;
         end
         OPC_AUIPC: begin
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_U; dec.alu_op = ALU_AUIPC;
         end
         OPC_JAL: begin
            dec.reg_write = 1'b1; dec.jal = 1'b1; dec.ext_op = EXT_J;
            dec.wd_sel = WD_PC; dec.alu_op = ALU_ADD;
         end
         OPC_JALR: begin
            uses_rs1 = 1'b1;
            dec.reg_write = 1'b1; dec.jalr = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
            dec.wd_sel = WD_PC; dec.alu_op = ALU_ADD;
            dec_legal = (funct3 == 3'b000);
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            dec.sbtype = 1'b1; dec.ext_op = EXT_B;
            case (funct3)
               3'b000:  dec.alu_op = ALU_SUB;
               3'b001:  dec.alu_op = ALU_BNE;
               3'b100:  dec.alu_op = ALU_BLT;
               3'b101:  dec.alu_op = ALU_BGE;
               3'b110:  dec.alu_op = ALU_BLTU;
               3'b111:  dec.alu_op = ALU_BGEU;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            uses_rs1 = 1'b1;
            dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1;
            dec.ext_op = EXT_I; dec.alu_op = ALU_ADD;
            case (funct3)
               3'b000:  begin dec.wd_sel = WD_B;  dec.dm_type = DM_BYTE;  end
               3'b001:  begin dec.wd_sel = WD_H;  dec.dm_type = DM_HALF;  end
               3'b010:  begin dec.wd_sel = WD_W;  dec.dm_type = DM_WORD;  end
               3'b100:  begin dec.wd_sel = WD_BU; dec.dm_type = DM_BYTEU; end
               3'b101:  begin dec.wd_sel = WD_HU; dec.dm_type = DM_HALFU; end
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            dec.mem_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_S; dec.alu_op = ALU_ADD;
            case (funct3)
               3'b000:  dec.dm_type = DM_BYTE;
               3'b001:  dec.dm_type = DM_HALF;
               3'b010:  dec.dm_type = DM_WORD;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_IMM: begin
            uses_rs1 = 1'b1;
            dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.ext_op = EXT_I;
            case (funct3)
               3'b000:  dec.alu_op = ALU_ADD;
               3'b010:  dec.alu_op = ALU_SLT;
               3'b011:  dec.alu_op = ALU_SLTU;
               3'b100:  dec.alu_op = ALU_XOR;
               3'b110:  dec.alu_op = ALU_OR;
               3'b111:  dec.alu_op = ALU_AND;
               3'b001: begin
                  dec.ext_op = EXT_SHAMT; dec.alu_op = ALU_SLL;
                  dec_legal = (funct7 == 7'b0000000);
               end
               default: begin
                  dec.ext_op = EXT_SHAMT;
                  dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               end
            endcase
         end
         OPC_REG: begin
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            dec.reg_write = 1'b1;
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  dec.alu_op = ALU_ADD;
                  3'b001:  dec.alu_op = ALU_SLL;
                  3'b010:  dec.alu_op = ALU_SLT;
                  3'b011:  dec.alu_op = ALU_SLTU;
                  3'b100:  dec.alu_op = ALU_XOR;
                  3'b101:  dec.alu_op = ALU_SRL;
                  3'b110:  dec.alu_op = ALU_OR;
                  default: dec.alu_op = ALU_AND;
               endcase
            end else if (funct7 == 7'b0100000) begin
               case (funct3)
                  3'b000:  dec.alu_op = ALU_SUB;
                  3'b101:  dec.alu_op = ALU_SRA;
                  default: dec_legal = 1'b0;
               endcase
`ifdef CTRL_RV32M_EN
            end else if (funct7 == 7'b0000001) begin
               dec_div = funct3[2];
               case (funct3)
                  3'b000:  dec.alu_op = ALU_MUL;
                  3'b001:  dec.alu_op = ALU_MULH;
                  3'b010:  dec.alu_op = ALU_MULHSU;
                  3'b011:  dec.alu_op = ALU_MULHU;
                  3'b100:  dec.alu_op = ALU_DIV;
                  3'b101:  dec.alu_op = ALU_DIVU;
                  3'b110:  dec.alu_op = ALU_REM;
                  default: dec.alu_op = ALU_REMU;
               endcase
`endif
            end else begin
               dec_legal = 1'b0;
            end
         end
         default: dec_legal = 1'b0;
      endcase
      // Undecodable instructions still travel down the pipe so EX can raise the trap.
      if (!dec_legal) begin
         dec = '0;
         dec.alu_op = ALU_NOP;
         dec.illegal = 1'b1;
`ifdef CTRL_RV32M_EN
         dec_div = 1'b0;
`endif
      end
      dec.rd  = id_inst[11:7];
      dec.rs1 = id_inst[19:15];
      dec.rs2 = id_inst[24:20];
   end

   assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                   ((uses_rs1 && (dec.rs1 == ctrl_q.rd)) || (uses_rs2 && (dec.rs2 == ctrl_q.rd)));
   assign id_ready = (state_q == RUN) && (!valid_q || ex_ready) && !hazard;
   assign accept   = id_valid && id_ready;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
`ifdef CTRL_RV32M_EN
      cnt_d   = cnt_q;
`endif
      if (flush) begin
         state_d = RUN;
         valid_d = 1'b0;
         ctrl_d  = '0;
`ifdef CTRL_RV32M_EN
         cnt_d   = '0;
`endif
      end else if (state_q == RUN) begin
         if (accept) begin
            ctrl_d  = dec;
            valid_d = 1'b1;
`ifdef CTRL_RV32M_EN
            // Divides sit in ID/EX invisible to EX until the divider has had its cycles.
            if (dec_div) begin
               valid_d = 1'b0;
               state_d = MDIV;
               cnt_d   = CNT_W'(DIV_LAT - 1);
            end
`endif
         end else if (ex_ready) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end
`ifdef CTRL_RV32M_EN
      end else begin
         if (cnt_q == '0) begin
            valid_d = 1'b1;
            state_d = RUN;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         ctrl_q  <= '0;
`ifdef CTRL_RV32M_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
`ifdef CTRL_RV32M_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign ex_valid    = valid_q;
   assign ex_RegWrite = ctrl_q.reg_write;
   assign ex_MemWrite = ctrl_q.mem_write;
   assign ex_MemRead  = ctrl_q.mem_read;
   assign ex_ALUSrc   = ctrl_q.alu_src;
   assign ex_sbtype   = ctrl_q.sbtype;
   assign ex_jal      = ctrl_q.jal;
   assign ex_jalr     = ctrl_q.jalr;
   assign ex_EXTOp    = ctrl_q.ext_op;
   assign ex_ALUOp    = ctrl_q.alu_op;
   assign ex_WDSel    = ctrl_q.wd_sel;
   assign ex_DMType   = ctrl_q.dm_type;
   assign ex_rd       = ctrl_q.rd;
   assign ex_rs1      = ctrl_q.rs1;
   assign ex_rs2      = ctrl_q.rs2;
   assign ex_illegal  = ctrl_q.illegal;
`ifdef CTRL_RV32M_EN
   assign ex_mbusy    = (state_q == MDIV);
`else
   assign ex_mbusy    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios followed by random traffic, all compared against
// a table-driven instruction model and a cycle-level ID/EX occupancy model.
module tb_ctrl_pipe;

   localparam int DIV_LAT = 8;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_inst;
   logic        id_ready;
   logic        ex_ready;
   logic        ex_valid;
   logic        ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
   logic        ex_sbtype, ex_jal, ex_jalr;
   logic [5:0]  ex_EXTOp;
   logic [4:0]  ex_ALUOp;
   logic [2:0]  ex_WDSel;
   logic [2:0]  ex_DMType;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic        ex_illegal;
   logic        ex_mbusy;

   ctrl_pipe #(.ALUOP_W(5), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .id_valid(id_valid), .id_inst(id_inst), .id_ready(id_ready),
      .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
      .ex_ALUSrc(ex_ALUSrc), .ex_sbtype(ex_sbtype), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_illegal(ex_illegal), .ex_mbusy(ex_mbusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rw, mw, mr, as, sb, jal, jalr;
      logic [5:0] ext;
      logic [4:0] alu;
      logic [2:0] wd, dm;
      logic [4:0] rd, rs1, rs2;
      logic       ill, dv, u1, u2;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic m_valid;
   exp_t m_exp;
   int   m_busy;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_ADD  = 32'h001101B3;
   localparam logic [31:0] I_SUB  = 32'h40208233;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_DIV  = 32'h027342B3;

   function automatic exp_t expDecode(input logic [31:0] inst);
      exp_t e;
      logic ok;
      logic [2:0] f3;
      logic [6:0] f7;
      e = '0;
      ok = 1'b1;
      f3 = inst[14:12];
      f7 = inst[31:25];
      case (inst[6:0])
         7'h37: begin e.rw = 1; e.as = 1; e.ext = 6'b000010; e.alu = 1; end
         7'h17: begin e.rw = 1; e.as = 1; e.ext = 6'b000010; e.alu = 2; end
         7'h6F: begin e.rw = 1; e.jal = 1; e.ext = 6'b000001; e.wd = 1; e.alu = 3; end
         7'h67: begin
            e.u1 = 1; ok = (f3 == 0);
            e.rw = 1; e.jalr = 1; e.as = 1; e.ext = 6'b010000; e.wd = 1; e.alu = 3;
         end
         7'h63: begin
            e.u1 = 1; e.u2 = 1; e.sb = 1; e.ext = 6'b000100;
            case (f3)
               0: e.alu = 4;  1: e.alu = 5;  4: e.alu = 6;
               5: e.alu = 7;  6: e.alu = 8;  7: e.alu = 9;
               default: ok = 0;
            endcase
         end
         7'h03: begin
            e.u1 = 1; e.rw = 1; e.mr = 1; e.as = 1; e.ext = 6'b010000; e.alu = 3;
            case (f3)
               0: begin e.wd = 4; e.dm = 3; end
               1: begin e.wd = 3; e.dm = 1; end
               2: begin e.wd = 2; e.dm = 0; end
               4: begin e.wd = 6; e.dm = 4; end
               5: begin e.wd = 5; e.dm = 2; end
               default: ok = 0;
            endcase
         end
         7'h23: begin
            e.u1 = 1; e.u2 = 1; e.mw = 1; e.as = 1; e.ext = 6'b001000; e.alu = 3;
            case (f3)
               0: e.dm = 3;  1: e.dm = 1;  2: e.dm = 0;
               default: ok = 0;
            endcase
         end
         7'h13: begin
            e.u1 = 1; e.rw = 1; e.as = 1; e.ext = 6'b010000;
            case (f3)
               0: e.alu = 3;  2: e.alu = 10; 3: e.alu = 11;
               4: e.alu = 12; 6: e.alu = 13; 7: e.alu = 14;
               1: begin e.ext = 6'b100000; e.alu = 15; ok = (f7 == 7'h00); end
               default: begin
                  e.ext = 6'b100000;
                  if (f7 == 7'h00) e.alu = 16;
                  else if (f7 == 7'h20) e.alu = 17;
                  else ok = 0;
               end
            endcase
         end
         7'h33: begin
            e.u1 = 1; e.u2 = 1; e.rw = 1;
            if (f7 == 7'h00) begin
               case (f3)
                  0: e.alu = 3;  1: e.alu = 15; 2: e.alu = 10; 3: e.alu = 11;
                  4: e.alu = 12; 5: e.alu = 16; 6: e.alu = 13; default: e.alu = 14;
               endcase
            end else if (f7 == 7'h20 && f3 == 0) e.alu = 4;
            else if (f7 == 7'h20 && f3 == 5) e.alu = 17;
`ifdef CTRL_RV32M_EN
            else if (f7 == 7'h01) begin
               e.alu = 5'd18 + 5'(f3);
               e.dv = f3[2];
            end
`endif
            else ok = 0;
         end
         default: ok = 0;
      endcase
      if (!ok) begin
         e.rw = 0; e.mw = 0; e.mr = 0; e.as = 0; e.sb = 0; e.jal = 0; e.jalr = 0;
         e.ext = 0; e.alu = 0; e.wd = 0; e.dm = 0; e.dv = 0; e.ill = 1;
      end
      e.rd  = inst[11:7];
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      return e;
   endfunction

   function automatic logic [31:0] randInst();
      logic [6:0] opc;
      logic [6:0] f7;
      case ($urandom_range(0, 10))
         0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
         4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
         8: opc = 7'h33;  9: opc = 7'h03;  default: opc = 7'h7F;
      endcase
      case ($urandom_range(0, 4))
         0, 1: f7 = 7'h00;
         2: f7 = 7'h20;
         3: f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
              5'($urandom_range(0, 3)), opc};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      checkOutput("ex_valid",    32'(ex_valid),    32'(m_valid));
      checkOutput("ex_mbusy",    32'(ex_mbusy),    32'(m_busy > 0));
      checkOutput("ex_RegWrite", 32'(ex_RegWrite), 32'(m_exp.rw));
      checkOutput("ex_MemWrite", 32'(ex_MemWrite), 32'(m_exp.mw));
      checkOutput("ex_MemRead",  32'(ex_MemRead),  32'(m_exp.mr));
      checkOutput("ex_ALUSrc",   32'(ex_ALUSrc),   32'(m_exp.as));
      checkOutput("ex_sbtype",   32'(ex_sbtype),   32'(m_exp.sb));
      checkOutput("ex_jal",      32'(ex_jal),      32'(m_exp.jal));
      checkOutput("ex_jalr",     32'(ex_jalr),     32'(m_exp.jalr));
      checkOutput("ex_EXTOp",    32'(ex_EXTOp),    32'(m_exp.ext));
      checkOutput("ex_ALUOp",    32'(ex_ALUOp),    32'(m_exp.alu));
      checkOutput("ex_WDSel",    32'(ex_WDSel),    32'(m_exp.wd));
      checkOutput("ex_DMType",   32'(ex_DMType),   32'(m_exp.dm));
      checkOutput("ex_illegal",  32'(ex_illegal),  32'(m_exp.ill));
      if (m_valid || m_busy > 0) begin
         checkOutput("ex_rd",  32'(ex_rd),  32'(m_exp.rd));
         checkOutput("ex_rs1", 32'(ex_rs1), 32'(m_exp.rs1));
         checkOutput("ex_rs2", 32'(ex_rs2), 32'(m_exp.rs2));
      end
   endtask

   task automatic modelReset();
      m_valid = 1'b0;
      m_exp   = '0;
      m_busy  = 0;
   endtask

   // One clock of traffic: drive, predict and check id_ready, advance the model, check ID/EX after the edge.
   task automatic applyStimulus(input logic iv, input logic [31:0] inst, input logic er, input logic fl);
      exp_t d;
      logic hz, rdy;
      @(negedge clk);
      id_valid = iv; id_inst = inst; ex_ready = er; flush = fl;
      #1;
      d   = expDecode(inst);
      hz  = m_valid && m_exp.mr && (m_exp.rd != 0) &&
            ((d.u1 && d.rs1 == m_exp.rd) || (d.u2 && d.rs2 == m_exp.rd));
      rdy = (m_busy == 0) && (!m_valid || er) && !hz;
      checkOutput("id_ready", 32'(id_ready), 32'(rdy));
      if (fl) begin
         modelReset();
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) m_valid = 1'b1;
      end else if (iv && rdy) begin
         m_exp = d;
         if (d.dv) begin
            m_busy  = DIV_LAT;
            m_valid = 1'b0;
         end else begin
            m_valid = 1'b1;
         end
      end else if (er) begin
         m_valid = 1'b0;
         m_exp   = '0;
      end
      @(posedge clk);
      #1;
      checkAll();
   endtask

   initial begin
      int busy_cnt;
      rstn = 1'b0; flush = 1'b0; id_valid = 1'b0; id_inst = '0; ex_ready = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      checkOutput("reset_id_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      applyStimulus(1, I_ADDI, 1, 0);
      checkOutput("addi_valid",  32'(ex_valid),  32'd1);
      checkOutput("addi_aluop",  32'(ex_ALUOp),  32'd3);
      checkOutput("addi_alusrc", 32'(ex_ALUSrc), 32'd1);
      checkOutput("addi_extop",  32'(ex_EXTOp),  32'b010000);
      checkOutput("addi_rd",     32'(ex_rd),     32'd1);

      applyStimulus(1, I_LW, 1, 0);
      checkOutput("lw_memread", 32'(ex_MemRead), 32'd1);
      applyStimulus(1, I_ADD, 1, 0);
      checkOutput("hazard_bubble", 32'(ex_valid), 32'd0);
      applyStimulus(1, I_ADD, 1, 0);
      checkOutput("add_after_bubble_valid", 32'(ex_valid), 32'd1);
      checkOutput("add_after_bubble_rd",    32'(ex_rd),    32'd3);

      applyStimulus(1, I_SUB, 1, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, I_ADDI, 0, 0);
         checkOutput("hold_aluop",    32'(ex_ALUOp), 32'd4);
         checkOutput("hold_id_ready", 32'(id_ready), 32'd0);
      end

      applyStimulus(1, I_BEQ, 1, 1);
      checkOutput("flush_valid",  32'(ex_valid),  32'd0);
      checkOutput("flush_sbtype", 32'(ex_sbtype), 32'd0);

      applyStimulus(1, 32'hFFFFFFFF, 1, 0);
      checkOutput("illegal_flag",     32'(ex_illegal),  32'd1);
      checkOutput("illegal_regwrite", 32'(ex_RegWrite), 32'd0);
      checkOutput("illegal_memwrite", 32'(ex_MemWrite), 32'd0);

      applyStimulus(1, I_DIV, 1, 0);
`ifdef CTRL_RV32M_EN
      busy_cnt = 0;
      for (int i = 0; i < 20 && ex_valid !== 1'b1; i++) begin
         if (ex_mbusy === 1'b1) busy_cnt++;
         applyStimulus(0, 32'h0, 1, 0);
      end
      checkOutput("div_busy_cycles", 32'(busy_cnt), 32'(DIV_LAT));
      checkOutput("div_valid",       32'(ex_valid), 32'd1);
      checkOutput("div_aluop",       32'(ex_ALUOp), 32'd22);
`else
      busy_cnt = 0;
      checkOutput("div_illegal", 32'(ex_illegal), 32'd1);
      checkOutput("div_mbusy",   32'(ex_mbusy),   32'(busy_cnt));
`endif

      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), randInst(),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      applyStimulus(1, I_LW, 1, 0);
      rstn = 1'b0;
      #2;
      modelReset();
      checkAll();
      checkOutput("midreset_id_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1, I_ADDI, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
